// File: rtl/floo_vc_rx_buffer.sv
// Receive side of a virtual-channel link: one first-word-fall-through FIFO per VC behind a registered ready_o.
// Define FLOO_VC_RX_ERR_EN to enable sticky protocol-error flags on err_o plus input assertions.
module floo_vc_rx_buffer #(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned NumPhysChannels = 1,
  parameter type         flit_t          = logic,
  parameter int unsigned FifoDepth       = 2,
  parameter int unsigned UsageWidth      = $clog2(FifoDepth + 1)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       test_enable_i,
  input  logic                                       flush_i,
  input  logic                                       err_clr_i,
  input  logic  [NumVirtChannels-1:0]                valid_i,
  output logic  [NumVirtChannels-1:0]                ready_o,
  input  flit_t [NumPhysChannels-1:0]                data_i,
  output logic  [NumVirtChannels-1:0]                valid_o,
  input  logic  [NumVirtChannels-1:0]                ready_i,
  output flit_t [NumVirtChannels-1:0]                data_o,
  output logic  [NumVirtChannels-1:0][UsageWidth-1:0] usage_o,
  output logic  [1:0]                                err_o
);

  localparam int unsigned           PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [UsageWidth-1:0] DepthU   = UsageWidth'(FifoDepth);
  localparam logic [PtrWidth-1:0]   LastPtr  = PtrWidth'(FifoDepth - 1);

  if (!((NumPhysChannels == 1) || (NumPhysChannels == NumVirtChannels))) begin : g_bad_lanes
    $fatal(1, "floo_vc_rx_buffer: NumPhysChannels must be 1 or NumVirtChannels");
  end

  logic [NumVirtChannels-1:0] w_ready;
  logic [NumVirtChannels-1:0] w_push_cand;
  logic [NumVirtChannels-1:0] w_push;
  logic [NumVirtChannels-1:0] w_pop;
  flit_t [NumVirtChannels-1:0] w_lane_data;
  logic                       w_unused_inputs;

  assign w_unused_inputs = test_enable_i ^ err_clr_i;
  assign w_push_cand     = valid_i & w_ready & {NumVirtChannels{~flush_i}};

  // A shared lane carries one flit per cycle: keep only the lowest-index candidate.
  if (NumPhysChannels == 1) begin : g_shared_grant
    assign w_push = w_push_cand & ~(w_push_cand - NumVirtChannels'(1));
  end else begin : g_own_grant
    assign w_push = w_push_cand;
  end

  for (genvar gi = 0; gi < NumVirtChannels; gi++) begin : g_vc
    flit_t                 r_mem [FifoDepth];
    logic [PtrWidth-1:0]   r_wr_ptr;
    logic [PtrWidth-1:0]   r_rd_ptr;
    logic [UsageWidth-1:0] r_cnt;
    logic                  r_rdy;
    logic [UsageWidth-1:0] w_cnt_next;
    logic [PtrWidth-1:0]   w_wr_ptr_next;
    logic [PtrWidth-1:0]   w_rd_ptr_next;

    if (NumPhysChannels == 1) begin : g_lane_shared
      assign w_lane_data[gi] = data_i[0];
    end else begin : g_lane_own
      assign w_lane_data[gi] = data_i[gi];
    end

    assign w_ready[gi] = r_rdy;
    assign ready_o[gi] = r_rdy;
    assign valid_o[gi] = (r_cnt != '0);
    assign usage_o[gi] = r_cnt;
    assign data_o[gi]  = r_mem[r_rd_ptr];
    assign w_pop[gi]   = valid_o[gi] & ready_i[gi];

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wr_ptr_next = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrWidth'(1);
    assign w_rd_ptr_next = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrWidth'(1);

    always_comb begin
      w_cnt_next = r_cnt;
      if (w_push[gi] && !w_pop[gi]) begin
        w_cnt_next = r_cnt + UsageWidth'(1);
      end else if (!w_push[gi] && w_pop[gi]) begin
        w_cnt_next = r_cnt - UsageWidth'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt    <= '0;
        r_rdy    <= 1'b1;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else if (flush_i) begin
        r_cnt    <= '0;
        r_rdy    <= 1'b1;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_cnt <= w_cnt_next;
        // Ready is granted only when space is guaranteed for the next cycle.
        r_rdy <= (w_cnt_next < DepthU);
        if (w_push[gi]) begin
          r_wr_ptr <= w_wr_ptr_next;
        end
        if (w_pop[gi]) begin
          r_rd_ptr <= w_rd_ptr_next;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < FifoDepth; i++) begin
          r_mem[i] <= '0;
        end
      end else if (w_push[gi]) begin
        r_mem[r_wr_ptr] <= w_lane_data[gi];
      end
    end
  end

`ifdef FLOO_VC_RX_ERR_EN
  logic [1:0] r_err;
  logic [1:0] w_err_set;

  assign w_err_set[0] = |(valid_i & ~w_ready);
  if (NumPhysChannels == 1) begin : g_collision
    assign w_err_set[1] = |(valid_i & (valid_i - NumVirtChannels'(1)));
  end else begin : g_no_collision
    assign w_err_set[1] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= '0;
    end else if (err_clr_i) begin
      r_err <= '0;
    end else begin
      r_err <= r_err | w_err_set;
    end
  end

  assign err_o = r_err;

  a_valid_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(valid_i));
  a_valid_ready_first: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                        ((valid_i & ~w_ready) == '0) || err_o[0] || w_err_set[0]);
`else
  assign err_o = '0;
`endif

endmodule

// File: tb/tb_floo_vc_rx_buffer.sv
// Directed plus randomized bench for floo_vc_rx_buffer with a per-VC scoreboard queue.
module tb_floo_vc_rx_buffer;

  typedef logic [7:0] flit_t;

`ifdef FLOO_VC_RX_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             test_enable_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             err_clr_i = 1'b0;
  logic [1:0]       valid_i = '0;
  logic [1:0]       ready_o;
  flit_t [0:0]      data_i = '0;
  logic [1:0]       valid_o;
  logic [1:0]       ready_i = '0;
  flit_t [1:0]      data_o;
  logic [1:0][1:0]  usage_o;
  logic [1:0]       err_o;

  always #5 clk_i = ~clk_i;

  floo_vc_rx_buffer #(
    .NumVirtChannels(2),
    .NumPhysChannels(1),
    .flit_t         (flit_t),
    .FifoDepth      (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .test_enable_i(test_enable_i),
    .flush_i      (flush_i),
    .err_clr_i    (err_clr_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .usage_o      (usage_o),
    .err_o        (err_o)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         mdl_cnt [2];
  logic [1:0] mdl_rdy;
  logic [1:0] mdl_err;
  flit_t      q0 [$];
  flit_t      q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("ready_o", 32'(ready_o), 32'(mdl_rdy));
    chk("valid_o", 32'(valid_o), {30'd0, mdl_cnt[1] != 0, mdl_cnt[0] != 0});
    chk("usage_o[0]", 32'(usage_o[0]), 32'(mdl_cnt[0]));
    chk("usage_o[1]", 32'(usage_o[1]), 32'(mdl_cnt[1]));
    chk("err_o", 32'(err_o), 32'(mdl_err));
  endtask

  // One clock of stimulus: pops are scored against the queue head before the edge,
  // accepted flits are queued at the edge, then the visible state is checked.
  task automatic step(input logic [1:0] v, input flit_t d, input logic [1:0] rdy,
                      input logic fl, input logic clr);
    logic [1:0] cand;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] eset;
    flit_t      head;
    @(negedge clk_i);
    valid_i   = v;
    data_i[0] = d;
    ready_i   = rdy;
    flush_i   = fl;
    err_clr_i = clr;
    cand    = v & mdl_rdy & {2{~fl}};
    push    = cand[0] ? 2'b01 : cand;
    pop[0]  = (mdl_cnt[0] != 0) && rdy[0] && !fl;
    pop[1]  = (mdl_cnt[1] != 0) && rdy[1] && !fl;
    eset[0] = |(v & ~mdl_rdy);
    eset[1] = (v == 2'b11);
    #1;
    if (pop[0]) begin
      head = q0.pop_front();
      chk("data_o[0]", 32'(data_o[0]), 32'(head));
    end
    if (pop[1]) begin
      head = q1.pop_front();
      chk("data_o[1]", 32'(data_o[1]), 32'(head));
    end
    @(posedge clk_i);
    if (fl) begin
      q0.delete();
      q1.delete();
      mdl_cnt[0] = 0;
      mdl_cnt[1] = 0;
    end else begin
      if (push[0]) q0.push_back(d);
      if (push[1]) q1.push_back(d);
      mdl_cnt[0] = mdl_cnt[0] + int'(push[0]) - int'(pop[0]);
      mdl_cnt[1] = mdl_cnt[1] + int'(push[1]) - int'(pop[1]);
    end
    mdl_rdy[0] = (mdl_cnt[0] < 2);
    mdl_rdy[1] = (mdl_cnt[1] < 2);
    if (ErrEn) mdl_err = clr ? 2'b00 : (mdl_err | eset);
    #1;
    check_state();
  endtask

  initial begin
    mdl_cnt[0] = 0;
    mdl_cnt[1] = 0;
    mdl_rdy    = 2'b11;
    mdl_err    = 2'b00;

    // Reset values while reset is held
    repeat (2) @(posedge clk_i);
    #1;
    check_state();
    chk("data_o_reset", 32'(data_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Idle after reset
    step(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);

    // Fill VC0 with consumer stalled; VC0 ready drops, VC1 stays ready
    step(2'b01, 8'hA1, 2'b00, 1'b0, 1'b0);
    step(2'b01, 8'hA2, 2'b00, 1'b0, 1'b0);

    // Violation on full VC0: flit dropped, usage stays 2
    step(2'b01, 8'h77, 2'b00, 1'b0, 1'b0);
    step(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
    step(2'b00, 8'h00, 2'b00, 1'b0, 1'b1);

    // Drain VC0 in order
    step(2'b00, 8'h00, 2'b01, 1'b0, 1'b0);
    step(2'b00, 8'h00, 2'b01, 1'b0, 1'b0);

    // Streaming on VC1 with consumer ready: one flit per cycle, ready never drops
    for (int i = 0; i < 10; i++) begin
      step(2'b10, flit_t'(i), 2'b11, 1'b0, 1'b0);
    end
    step(2'b00, 8'h00, 2'b11, 1'b0, 1'b0);
    step(2'b00, 8'h00, 2'b11, 1'b0, 1'b0);

    // Lane collision: only VC0 stores the flit
    step(2'b11, 8'h55, 2'b00, 1'b0, 1'b0);
    step(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
    step(2'b00, 8'h00, 2'b00, 1'b0, 1'b1);
    step(2'b00, 8'h00, 2'b11, 1'b0, 1'b0);

    // One entry per VC, then flush with a pop and an incoming flit in the same cycle
    step(2'b01, 8'hC0, 2'b00, 1'b0, 1'b0);
    step(2'b10, 8'hC1, 2'b00, 1'b0, 1'b0);
    step(2'b01, 8'hEE, 2'b11, 1'b1, 1'b0);
    step(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);

    // Flush and error clear together
    step(2'b11, 8'h33, 2'b00, 1'b0, 1'b0);
    step(2'b00, 8'h00, 2'b00, 1'b1, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      step(2'($urandom_range(0, 3)), flit_t'($urandom), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 8'h00, 2'b11, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
